data_bus_responder: RTL and testbench

Responder on the core's data-memory port: it accepts `mem_addr`, `mem_wr_data` and `mem_wr_sig` from the MEM stage and returns `mem_rd_data` in the same cycle. It decodes the address into a word RAM and a small MMIO region: GPIO, a UART transmitter, a 64-bit cycle counter and a compare timer. It sits beside the core in the top level, opposite the instruction ROM.

---
 rtl/data_bus_responder_if.sv | 23 ++
 rtl/data_bus_responder.sv | 145 ++++++++++++++
 tb/tb_data_bus_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_responder_if.sv
// Data-memory port between the core's MEM stage and its responder.
// Latency: read data is combinational from the address; writes commit on the clock edge.
// Backpressure: none; the responder accepts every access in the cycle it is presented.
interface data_bus_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_sig;
  logic [31:0] mem_rd_data;

  modport master (
    output mem_addr,
    output mem_wr_data,
    output mem_wr_sig,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_data,
    input  mem_wr_sig,
    output mem_rd_data
  );
endinterface

// File: rtl/data_bus_responder.sv
// Data-memory responder: word RAM plus MMIO (GPIO, UART TX, 64-bit cycle counter, compare timer).
// Latency: reads are combinational in the access cycle; writes take effect on the next rising edge.
// Backpressure: none; a UART write while a frame is in flight is silently dropped (software polls busy).
module data_bus_responder #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned BAUD_DIV  = 434
) (
  input  logic                     clk,
  input  logic                     reset_n,
  data_bus_responder_if.slave      bus,
  output logic [7:0]               gpio_o,
  output logic                     uart_tx_o,
  output logic                     timer_irq_o
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  // Address decode: RAM occupies the bottom of the map, MMIO is a 32-byte window at 0x8000_0000.
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          mmio_hit;
  logic [2:0]    reg_sel;
  logic          wr;
  logic          unused_addr_bits;

  assign ram_idx          = bus.mem_addr[AW+1:2];
  assign ram_hit          = (bus.mem_addr[31:AW+2] == '0);
  assign mmio_hit         = (bus.mem_addr[31:5] == 27'h400_0000);
  assign reg_sel          = bus.mem_addr[4:2];
  assign wr               = bus.mem_wr_sig;
  assign unused_addr_bits = ^bus.mem_addr[1:0];

  logic ram_wr, gpio_wr, uart_wr, cyc_clr, cmp_wr, stat_wr;
  assign ram_wr  = wr && ram_hit;
  assign gpio_wr = wr && mmio_hit && (reg_sel == 3'd0);
  assign uart_wr = wr && mmio_hit && (reg_sel == 3'd1);
  assign cyc_clr = wr && mmio_hit && ((reg_sel == 3'd2) || (reg_sel == 3'd3));
  assign cmp_wr  = wr && mmio_hit && (reg_sel == 3'd4);
  assign stat_wr = wr && mmio_hit && (reg_sel == 3'd5);

  logic [31:0] ram [RAM_WORDS];
  logic [63:0] cycle_cnt;
  logic [31:0] timer_cmp;
  logic        pending;

  uart_state_t     state, state_nxt;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      tx_byte;
  logic            baud_last;
  logic            uart_busy;
  logic            uart_go;

  assign baud_last   = (baud_cnt == BAUD_LAST);
  assign uart_busy   = (state != U_IDLE);
  assign uart_go     = uart_wr && !uart_busy;
  assign timer_irq_o = pending;

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) ram[ram_idx] <= bus.mem_wr_data;
  end

  // GPIO, cycle counter, timer compare and sticky pending flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_o    <= 8'd0;
      cycle_cnt <= 64'd0;
      timer_cmp <= 32'hFFFF_FFFF;
      pending   <= 1'b0;
    end else begin
      if (gpio_wr) gpio_o <= bus.mem_wr_data[7:0];
      // A clear write beats the increment so the counter shows 0 next cycle.
      cycle_cnt <= cyc_clr ? 64'd0 : cycle_cnt + 64'd1;
      if (cmp_wr) timer_cmp <= bus.mem_wr_data;
      // Match uses the pre-increment count; a coincident set beats a software clear.
      if (cycle_cnt[31:0] == timer_cmp)           pending <= 1'b1;
      else if (stat_wr && bus.mem_wr_data[0])     pending <= 1'b0;
    end
  end

  // UART state register plus baud counter, bit index and shift byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= U_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      tx_byte  <= 8'd0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= (state == U_IDLE || baud_last) ? '0 : baud_cnt + BW'(1);
      if (uart_go) begin
        tx_byte <= bus.mem_wr_data[7:0];
        bit_idx <= 3'd0;
      end else if (state == U_DATA && baud_last) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // UART next-state: each phase lasts one baud period, DATA repeats for eight bits.
  always_comb begin
    state_nxt = state;
    case (state)
      U_IDLE:  if (uart_go)                        state_nxt = U_START;
      U_START: if (baud_last)                      state_nxt = U_DATA;
      U_DATA:  if (baud_last && bit_idx == 3'd7)   state_nxt = U_STOP;
      U_STOP:  if (baud_last)                      state_nxt = U_IDLE;
      default:                                     state_nxt = U_IDLE;
    endcase
  end

  // UART line level decoded from state so it changes on the same edge as the state.
  always_comb begin
    uart_tx_o = 1'b1;
    case (state)
      U_START: uart_tx_o = 1'b0;
      U_DATA:  uart_tx_o = tx_byte[bit_idx];
      default: uart_tx_o = 1'b1;
    endcase
  end

  // Combinational read mux; unmapped addresses return 0.
  always_comb begin
    bus.mem_rd_data = 32'd0;
    if (ram_hit) begin
      bus.mem_rd_data = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        3'd0:    bus.mem_rd_data = {24'd0, gpio_o};
        3'd1:    bus.mem_rd_data = {31'd0, uart_busy};
        3'd2:    bus.mem_rd_data = cycle_cnt[31:0];
        3'd3:    bus.mem_rd_data = cycle_cnt[63:32];
        3'd4:    bus.mem_rd_data = timer_cmp;
        3'd5:    bus.mem_rd_data = {31'd0, pending};
        default: bus.mem_rd_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder with BAUD_DIV = 4.
// Latency: reads sampled 1-2 time units after each rising edge; writes commit on the following edge.
// Backpressure: none modelled; the bench drives one access per cycle.
module tb_data_bus_responder;
  localparam logic [31:0] A_GPIO = 32'h8000_0000;
  localparam logic [31:0] A_UART = 32'h8000_0004;
  localparam logic [31:0] A_CLO  = 32'h8000_0008;
  localparam logic [31:0] A_CHI  = 32'h8000_000C;
  localparam logic [31:0] A_CMP  = 32'h8000_0010;
  localparam logic [31:0] A_STAT = 32'h8000_0014;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] gpio_o;
  logic       uart_tx_o;
  logic       timer_irq_o;
  logic [31:0] rd;
  int         n_cmp = 0;
  int         n_err = 0;

  data_bus_responder_if bus();

  data_bus_responder #(.RAM_WORDS(1024), .BAUD_DIV(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .gpio_o      (gpio_o),
    .uart_tx_o   (uart_tx_o),
    .timer_irq_o (timer_irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.mem_wr_sig = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_addr    = a;
    bus.mem_wr_data = d;
    bus.mem_wr_sig  = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_wr_sig  = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bus.mem_addr   = a;
    bus.mem_wr_sig = 1'b0;
    #1;
    d = bus.mem_rd_data;
  endtask

  // Expected line level in cycle c of a frame carrying byte b (4 cycles per bit).
  function automatic logic exp_tx(input int c, input logic [7:0] b);
    int k;
    k = c / 4;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  initial begin
    int lows;
    logic [7:0] byte_v;
    reset_n         = 1'b0;
    bus.mem_addr    = 32'd0;
    bus.mem_wr_data = 32'd0;
    bus.mem_wr_sig  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio", gpio_o, 8'h00);
    check("rst_tx", uart_tx_o, 1'b1);
    check("rst_irq", timer_irq_o, 1'b0);
    #1 reset_n = 1'b1;
    bus_rd(A_CLO, rd); check("cyc_first", rd, 32'd0);
    @(posedge clk); #1;
    bus_rd(A_CLO, rd); check("cyc_second", rd, 32'd1);
    bus_rd(A_CMP, rd);  check("rst_cmp", rd, 32'hFFFF_FFFF);
    bus_rd(A_UART, rd); check("rst_busy", rd, 32'd0);
    bus_rd(A_STAT, rd); check("rst_stat", rd, 32'd0);

    // RAM
    bus_wr(32'h0000_0000, 32'h0000_0000);
    bus_wr(32'h0000_0014, 32'h1111_1111);
    bus_wr(32'h0000_0010, 32'hDEAD_BEEF);
    bus_rd(32'h0000_0010, rd); check("ram_rd10", rd, 32'hDEAD_BEEF);
    bus_rd(32'h0000_0013, rd); check("ram_rd13", rd, 32'hDEAD_BEEF);
    bus_rd(32'h0000_0014, rd); check("ram_rd14", rd, 32'h1111_1111);
    bus.mem_addr    = 32'h0000_0010;
    bus.mem_wr_data = 32'hCAFE_F00D;
    bus.mem_wr_sig  = 1'b1;
    #1 check("ram_same_cycle_old", bus.mem_rd_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    bus.mem_wr_sig = 1'b0;
    #1 check("ram_next_cycle_new", bus.mem_rd_data, 32'hCAFE_F00D);
    bus_wr(32'h4000_0000, 32'h5A5A_5A5A);
    bus_rd(32'h4000_0000, rd); check("unmapped_rd", rd, 32'd0);
    bus_rd(32'h0000_0000, rd); check("unmapped_no_alias", rd, 32'd0);
    bus_rd(32'h8000_0018, rd); check("unmapped_mmio", rd, 32'd0);

    // GPIO
    bus_wr(A_GPIO, 32'h1234_56A5);
    check("gpio_out", gpio_o, 8'hA5);
    bus_rd(A_GPIO, rd); check("gpio_rd", rd, 32'h0000_00A5);

    // Cycle counter
    bus_wr(A_CLO, 32'h0000_1234);
    bus_rd(A_CLO, rd); check("clr_lo", rd, 32'd0);
    bus_rd(A_CHI, rd); check("clr_hi", rd, 32'd0);
    idle(5);
    bus_rd(A_CLO, rd); check("cnt_5", rd, 32'd5);
    bus_wr(A_CHI, 32'h0);
    bus_rd(A_CLO, rd); check("clr_via_hi", rd, 32'd0);
    @(negedge clk);
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.cycle_cnt;
    @(posedge clk); #1;
    bus_rd(A_CLO, rd); check("pre_wrap_lo", rd, 32'hFFFF_FFFF);
    bus_rd(A_CHI, rd); check("pre_wrap_hi", rd, 32'd0);
    idle(1);
    bus_rd(A_CLO, rd); check("wrap_lo", rd, 32'd0);
    bus_rd(A_CHI, rd); check("wrap_hi", rd, 32'd1);
    check("match_reset_cmp", timer_irq_o, 1'b1);
    bus_wr(A_STAT, 32'd1);
    check("stat_clear", timer_irq_o, 1'b0);

    // Timer
    bus_wr(A_CLO, 32'd0);
    bus_wr(A_CMP, 32'd20);
    bus_rd(A_CMP, rd); check("cmp_rd", rd, 32'd20);
    idle(19);
    bus_rd(A_CLO, rd); check("tmr_lo20", rd, 32'd20);
    check("tmr_irq_c20", timer_irq_o, 1'b0);
    idle(1);
    check("tmr_irq_c21", timer_irq_o, 1'b1);
    idle(5);
    check("tmr_sticky", timer_irq_o, 1'b1);
    bus_wr(A_CLO, 32'd0);
    bus_wr(A_STAT, 32'd1);
    check("tmr_clr_early", timer_irq_o, 1'b0);
    idle(19);
    bus_rd(A_CLO, rd); check("tmr2_lo20", rd, 32'd20);
    bus_wr(A_STAT, 32'd1);
    check("tmr_set_wins", timer_irq_o, 1'b1);
    bus_rd(A_STAT, rd); check("stat_rd", rd, 32'd1);
    bus_wr(A_STAT, 32'd1);
    check("tmr_late_clear", timer_irq_o, 1'b0);

    // UART frame with a dropped second write
    byte_v = 8'h53;
    bus_wr(A_UART, 32'h0000_0053);
    for (int c = 0; c < 40; c++) begin
      check($sformatf("tx_c%0d", c), uart_tx_o, exp_tx(c, byte_v));
      bus_rd(A_UART, rd); check($sformatf("busy_c%0d", c), rd, 32'd1);
      if (c == 10) bus_wr(A_UART, 32'h0000_00FF);
      else idle(1);
    end
    check("tx_idle_after", uart_tx_o, 1'b1);
    bus_rd(A_UART, rd); check("busy_cleared", rd, 32'd0);
    lows = 0;
    for (int c = 0; c < 48; c++) begin
      if (uart_tx_o !== 1'b1) lows++;
      idle(1);
    end
    check("no_second_frame", lows, 0);

    // Reset mid-frame
    bus_wr(A_GPIO, 32'h0000_003C);
    bus_wr(A_UART, 32'h0000_000E);
    idle(6);
    check("tx_data_bit0", uart_tx_o, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("arst_tx", uart_tx_o, 1'b1);
    check("arst_gpio", gpio_o, 8'h00);
    check("arst_irq", timer_irq_o, 1'b0);
    bus_rd(A_UART, rd); check("arst_busy", rd, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    bus_rd(A_CLO, rd); check("rel_cyc0", rd, 32'd0);
    bus_rd(A_CMP, rd); check("rel_cmp", rd, 32'hFFFF_FFFF);
    byte_v = 8'hA6;
    bus_wr(A_UART, 32'h0000_00A6);
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 1) check($sformatf("tx2_c%0d", c), uart_tx_o, exp_tx(c, byte_v));
      idle(1);
    end
    bus_rd(A_UART, rd); check("busy2_cleared", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
